// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants, pixel type and window helper shared by the framebuffer arbiter
package vga_pkg;
  localparam int DATA_W = 8;
  localparam int H_VIS_START = 160;
  localparam int H_VIS_END = 800;
  localparam int V_VIS_START = 45;
  localparam int V_VIS_END = 525;
  localparam int FB_DEPTH = (H_VIS_END - H_VIS_START) * (V_VIS_END - V_VIS_START);
  typedef logic [DATA_W-1:0] pixel_t;
  function automatic logic in_range(input int x, input int lo, input int hi);
    return x >= lo && x < hi;
  endfunction
endpackage

// File: rtl/vga_fb_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant, searching from a pointer that moves past each winner
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, nxt, idx;
  logic hit;
  // First requester at or after the pointer wins; pointer moves one past it
  always_comb begin
    gnt = '0;
    nxt = ptr;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (enable && !hit && req[idx]) begin
        hit = 1'b1;
        gnt[idx] = 1'b1;
        nxt = PW'((int'(idx) + 1) % N);
      end
    end
  end
  // Pointer register; unchanged when nothing is granted
  always_ff @(posedge i_clk) ptr <= i_rst ? '0 : nxt;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: framebuffer RAM owner, scanout first, writers round-robin; VGA_FB_ARB_TEARFREE_EN limits writes to vblank
module vga_fb_arbiter #(
  parameter int DATA_W = vga_pkg::DATA_W,
  parameter int ADDR_W = 19,
  parameter int N_WR = 2,
  parameter int H_VIS_START = vga_pkg::H_VIS_START,
  parameter int H_VIS_END = vga_pkg::H_VIS_END,
  parameter int V_VIS_START = vga_pkg::V_VIS_START,
  parameter int V_VIS_END = vga_pkg::V_VIS_END
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [10:0]            i_hpos,
  input  logic [9:0]             i_vpos,
  input  logic [N_WR-1:0]        i_wr_req,
  input  logic [N_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [N_WR*DATA_W-1:0] i_wr_data,
  output logic [N_WR-1:0]        o_wr_gnt,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic                   o_mem_we,
  output logic [DATA_W-1:0]      o_mem_wdata,
  input  logic [DATA_W-1:0]      i_mem_rdata,
  output logic [DATA_W-1:0]      o_pixel,
  output logic                   o_pixel_valid,
  output logic                   o_frame_start
);
  import vga_pkg::*;
  localparam int DEPTH = (H_VIS_END - H_VIS_START) * (V_VIS_END - V_VIS_START);
  logic synced, sof, v_vis, scan_slot, scan_d, wr_en;
  logic [ADDR_W-1:0] scan_cnt, sel_addr;
  logic [DATA_W-1:0] sel_data;
  assign sof = i_hpos == '0 && i_vpos == '0;
  assign v_vis = in_range(int'(i_vpos), V_VIS_START, V_VIS_END);
  assign scan_slot = synced && v_vis && in_range(int'(i_hpos), H_VIS_START - 2, H_VIS_END - 2);
`ifdef VGA_FB_ARB_TEARFREE_EN
  assign wr_en = !i_rst && !v_vis;
`else
  assign wr_en = !i_rst && !scan_slot;
`endif
  rr_arbiter #(.N(N_WR)) u_rr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .req    (i_wr_req),
    .enable (wr_en),
    .gnt    (o_wr_gnt)
  );
  // Steer the granted writer onto the RAM port; zero when idle
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N_WR; k++)
      if (o_wr_gnt[k]) begin
        sel_addr = i_wr_addr[k*ADDR_W +: ADDR_W];
        sel_data = i_wr_data[k*DATA_W +: DATA_W];
      end
  end
  assign o_mem_addr = scan_slot ? scan_cnt : sel_addr;
  assign o_mem_we = |o_wr_gnt && int'(sel_addr) < DEPTH;
  assign o_mem_wdata = sel_data;
  // Frame sync, scan address counter and two-stage pixel fetch pipeline
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      synced <= 1'b0;
      scan_cnt <= '0;
      scan_d <= 1'b0;
      o_pixel <= '0;
      o_pixel_valid <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      synced <= synced || sof;
      scan_cnt <= sof ? '0 : scan_slot ? scan_cnt + ADDR_W'(1) : scan_cnt;
      scan_d <= scan_slot;
      o_pixel <= scan_d ? i_mem_rdata : '0;
      o_pixel_valid <= scan_d;
      o_frame_start <= sof;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks on a reduced-geometry instance (64x8 visible, 84x11 total)
module tb_vga_fb_arbiter;
  localparam int HS = 20, HE = 84, VS = 3, VE = 11, DEPTH = 512;
  logic clk, rst;
  logic [10:0] hpos;
  logic [9:0] vpos;
  logic [1:0] wr_req, gnt;
  logic [37:0] wr_addr;
  logic [15:0] wr_data;
  logic [18:0] mem_addr;
  logic mem_we, valid, fs;
  logic [7:0] mem_wdata, mem_rdata, pixel;
  logic [7:0] ram [0:1023];
  int h, v, n_checks, n_fail, bad, gh, gv;

  vga_fb_arbiter #(
    .DATA_W(8), .ADDR_W(19), .N_WR(2),
    .H_VIS_START(HS), .H_VIS_END(HE), .V_VIS_START(VS), .V_VIS_END(VE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_hpos(hpos), .i_vpos(vpos),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_gnt(gnt), .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_pixel(pixel), .o_pixel_valid(valid), .o_frame_start(fs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int a = 0; a < 1024; a++) ram[a] = 8'(a);
    forever begin
      @(posedge clk);
      mem_rdata <= ram[mem_addr[9:0]];
      if (mem_we) ram[mem_addr[9:0]] = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (h == HE - 1) begin
      h = 0;
      v = (v == VE - 1) ? 0 : v + 1;
    end else h++;
    hpos = 11'(h);
    vpos = 10'(v);
    #1;
  endtask

  task automatic run_to(input int th, input int tv);
    int n = 0;
    while (!(h == th && v == tv) && n < 3000) begin
      tick();
      n++;
    end
    check("run_to", 32'(h == th && v == tv), 1);
  endtask

  task automatic sync_no_valid(input string tag);
    int n = 0;
    bad = 0;
    while (!(h == 0 && v == 0) && n < 3000) begin
      if (valid !== 1'b0) bad++;
      tick();
      n++;
    end
    check(tag, 32'(bad), 0);
    check("sync_reached", 32'(h == 0 && v == 0), 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    h = 40;
    v = 5;
    hpos = 11'(h);
    vpos = 10'(v);
    rst = 1'b1;
    wr_req = 2'b11;
    wr_addr = {19'd2, 19'd1};
    wr_data = {8'h22, 8'h11};
    repeat (3) begin
      tick();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_we", 32'(mem_we), 0);
    end
    check("rst_pixel", 32'(pixel), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_fs", 32'(fs), 0);
    check("rst_cnt", 32'(dut.scan_cnt), 0);
    rst = 1'b0;
    wr_req = 2'b00;
    sync_no_valid("pre_sync_valid");
    tick();
    check("fs_pulse", 32'(fs), 1);
    check("cnt_clear", 32'(dut.scan_cnt), 0);
    repeat (HE * VE - 1) begin
      tick();
      check("fs_low", 32'(fs), 0);
      check("valid", 32'(valid), 32'(v >= VS && v < VE && h >= HS && h < HE));
      if (v >= VS && v < VE && h >= HS && h < HE)
        check("pixel", 32'(pixel), 32'(((v - VS) * (HE - HS) + h - HS) & 8'hFF));
      if (h == HE - 1 && v == VE - 1) check("cnt_end", 32'(dut.scan_cnt), DEPTH);
    end
    tick();
    check("fs_pulse2", 32'(fs), 1);
    check("cnt_clear2", 32'(dut.scan_cnt), 0);
    run_to(80, 2);
    wr_req = 2'b11;
    wr_addr = {19'd301, 19'd300};
    wr_data = {8'h44, 8'h33};
    #1;
    check("rr0_gnt", 32'(gnt), 32'b01);
    check("rr0_addr", 32'(mem_addr), 300);
    check("rr0_data", 32'(mem_wdata), 32'h33);
    check("rr0_we", 32'(mem_we), 1);
    tick();
    check("rr1_gnt", 32'(gnt), 32'b10);
    check("rr1_addr", 32'(mem_addr), 301);
    check("rr1_data", 32'(mem_wdata), 32'h44);
    tick();
    check("rr2_gnt", 32'(gnt), 32'b01);
    tick();
    check("rr3_gnt", 32'(gnt), 32'b10);
    bad = 0;
    for (int n = 0; n < 3000 && !(v == 3 && h == 82); n++) begin
      if (v == 3 && h >= HS - 2 && h < HE - 2 && gnt !== 2'b00) bad++;
      tick();
    end
    check("slot_no_gnt", 32'(bad), 0);
    wr_req = 2'b00;
    #1;
    check("ram300", 32'(ram[300]), 32'h33);
    run_to(40, 5);
    wr_req = 2'b10;
    wr_addr = {19'd341, 19'd0};
    wr_data = {8'h5A, 8'h00};
    #1;
    for (int n = 0; n < 3000 && gnt == 2'b00; n++) tick();
    gh = h;
    gv = v;
`ifdef VGA_FB_ARB_TEARFREE_EN
    check("w1_gnt_h", 32'(gh), 0);
    check("w1_gnt_v", 32'(gv), 0);
`else
    check("w1_gnt_h", 32'(gh), HE - 2);
    check("w1_gnt_v", 32'(gv), 5);
`endif
    check("w1_gnt", 32'(gnt), 32'b10);
    check("w1_we", 32'(mem_we), 1);
    check("w1_addr", 32'(mem_addr), 341);
    check("w1_data", 32'(mem_wdata), 32'h5A);
    tick();
    wr_req = 2'b00;
    #1;
    check("ram341", 32'(ram[341]), 32'h5A);
    run_to(10, 1);
    wr_req = 2'b01;
    wr_addr = {19'd0, 19'(DEPTH)};
    wr_data = {8'h00, 8'hA5};
    #1;
    check("oor_gnt", 32'(gnt), 32'b01);
    check("oor_we", 32'(mem_we), 0);
    tick();
    wr_req = 2'b00;
    #1;
    check("oor_ram", 32'(ram[DEPTH]), 0);
    run_to(40, 5);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_cnt", 32'(dut.scan_cnt), 0);
    sync_no_valid("mid_rst_pre_sync_valid");
    run_to(HS - 1, VS);
    check("first_pre", 32'(valid), 0);
    tick();
    check("first_valid", 32'(valid), 1);
    check("first_pixel", 32'(pixel), 32'(ram[0]));
    tick();
    check("second_pixel", 32'(pixel), 32'(ram[1]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
